// File: rtl/ascii_calc_seq.sv
// ASCII keypad calculator: assembles decimal operands character by character,
// computes + - * / (restoring divider) and converts the result with double-dabble.
module ascii_calc_seq #(
    parameter  int DIGITS = 2,
    localparam int NW     = $clog2(10**DIGITS),
    localparam int RW     = 2*NW,
    localparam int RD     = 2*DIGITS
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [8*RD-1:0] res_ascii,
    output logic          res_neg,
    output logic          res_valid,
    output logic          err,
    output logic [2:0]    dbg_state
);
    // Handshake: a character is consumed on any rising edge where in_valid && in_ready;
    // the source holds in_valid/in_data stable until that edge.
    localparam int MAXV = 10**DIGITS - 1;
    localparam int CW   = $clog2(RW+1);

    typedef enum logic [2:0] {S_A, S_B, S_DIV, S_CONV, S_RES} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t          state_q;
    op_t             op_q, op_d;
    logic [NW-1:0]   a_q, b_q, rem_q, dvd_q;
    logic [2:0]      cnt_a_q, cnt_b_q;
    logic            neg_q;
    logic [RW-1:0]   r_q, bin_q;
    logic [4*RD-1:0] bcd_q;
    logic [CW-1:0]   step_q;
    logic [8*RD-1:0] res_ascii_q;
    logic            res_neg_q, res_valid_q, err_q, in_ready_q;

    logic            acc, is_digit, is_op;
    logic [NW-1:0]   a_dig_d, b_dig_d, rem_nx_d, quo_nx_d;
    logic [NW:0]     trial_d;
    logic            div_ge_d;
    logic [RW-1:0]   calc_d;
    logic            calc_neg_d;
    logic [4*RD-1:0] bcd_adj_d;

    always_comb begin
        acc      = in_valid && in_ready_q;
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_op    = (in_data == 8'h2B) || (in_data == 8'h2D) ||
                   (in_data == 8'h2A) || (in_data == 8'h2F);
        a_dig_d  = a_q * NW'(10) + NW'(in_data[3:0]);
        b_dig_d  = b_q * NW'(10) + NW'(in_data[3:0]);
        op_d = OP_ADD;
        case (in_data)
            8'h2D:   op_d = OP_SUB;
            8'h2A:   op_d = OP_MUL;
            8'h2F:   op_d = OP_DIV;
            default: op_d = OP_ADD;
        endcase
        calc_neg_d = 1'b0;
        calc_d     = '0;
        case (op_q)
            OP_ADD: calc_d = RW'(a_q) + RW'(b_q);
            OP_SUB: begin
                calc_neg_d = (a_q < b_q);
                calc_d     = calc_neg_d ? RW'(b_q - a_q) : RW'(a_q - b_q);
            end
            OP_MUL: calc_d = RW'(a_q) * RW'(b_q);
            default: calc_d = '0;
        endcase
        trial_d  = {rem_q, dvd_q[NW-1]};
        div_ge_d = (trial_d >= {1'b0, b_q});
        rem_nx_d = div_ge_d ? NW'(trial_d - {1'b0, b_q}) : trial_d[NW-1:0];
        quo_nx_d = {dvd_q[NW-2:0], div_ge_d};
        // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
        bcd_adj_d = bcd_q;
        for (int i = 0; i < RD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_A;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            neg_q       <= 1'b0;
            r_q         <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            res_ascii_q <= {RD{8'h30}};
            res_neg_q   <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_A, S_B, S_RES: if (acc) begin
                    if (in_data == 8'h63) begin
                        a_q         <= '0;
                        b_q         <= '0;
                        cnt_a_q     <= '0;
                        cnt_b_q     <= '0;
                        err_q       <= 1'b0;
                        res_ascii_q <= {RD{8'h30}};
                        res_neg_q   <= 1'b0;
                        state_q     <= S_A;
                    end else if (state_q == S_A) begin
                        if (is_digit) begin
                            if (cnt_a_q == 3'(DIGITS)) err_q <= 1'b1;
                            else begin
                                a_q     <= a_dig_d;
                                cnt_a_q <= cnt_a_q + 3'd1;
                            end
                        end else if (is_op && cnt_a_q != '0) begin
                            op_q    <= op_d;
                            b_q     <= '0;
                            cnt_b_q <= '0;
                            state_q <= S_B;
                        end
                    end else if (state_q == S_B) begin
                        if (is_digit) begin
                            if (cnt_b_q == 3'(DIGITS)) err_q <= 1'b1;
                            else begin
                                b_q     <= b_dig_d;
                                cnt_b_q <= cnt_b_q + 3'd1;
                            end
                        end else if (in_data == 8'h3D && cnt_b_q != '0) begin
                            neg_q      <= calc_neg_d;
                            in_ready_q <= 1'b0;
                            step_q     <= '0;
                            if (op_q == OP_DIV && b_q != '0) begin
                                rem_q   <= '0;
                                dvd_q   <= a_q;
                                state_q <= S_DIV;
                            end else begin
                                // Divide-by-zero lands here too, with calc_d forced to 0.
                                if (op_q == OP_DIV) err_q <= 1'b1;
                                r_q     <= calc_d;
                                bin_q   <= calc_d;
                                bcd_q   <= '0;
                                state_q <= S_CONV;
                            end
                        end
                    end else begin
                        if (is_digit) begin
                            a_q     <= NW'(in_data[3:0]);
                            cnt_a_q <= 3'd1;
                            b_q     <= '0;
                            cnt_b_q <= '0;
                            state_q <= S_A;
                        end else if (is_op) begin
                            if (!neg_q && r_q <= RW'(MAXV)) begin
                                a_q     <= r_q[NW-1:0];
                                cnt_a_q <= 3'd1;
                                op_q    <= op_d;
                                b_q     <= '0;
                                cnt_b_q <= '0;
                                state_q <= S_B;
                            end else err_q <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nx_d;
                    dvd_q <= quo_nx_d;
                    if (step_q == CW'(NW-1)) begin
                        r_q     <= RW'(quo_nx_d);
                        bin_q   <= RW'(quo_nx_d);
                        bcd_q   <= '0;
                        step_q  <= '0;
                        state_q <= S_CONV;
                    end else step_q <= step_q + CW'(1);
                end
                S_CONV: begin
                    if (step_q != CW'(RW)) begin
                        bcd_q  <= {bcd_adj_d[4*RD-2:0], bin_q[RW-1]};
                        bin_q  <= {bin_q[RW-2:0], 1'b0};
                        step_q <= step_q + CW'(1);
                    end else begin
                        for (int i = 0; i < RD; i++) res_ascii_q[8*i +: 8] <= {4'h3, bcd_q[4*i +: 4]};
                        res_neg_q   <= neg_q;
                        res_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_RES;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_ascii = res_ascii_q;
    assign res_neg   = res_neg_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign dbg_state = state_q;
endmodule
